data_bus_scanner: RTL and testbench

- Reader side of the 4-source computer data bus: drives select lines s1:s0 to the bus multiplexer and samples the shared 1-bit bus line d.
- Sequences through sources i0..i3, waits a settle interval after each select change, captures each bit, then publishes a 4-bit word with a one-cycle valid pulse and a changed flag.
- Feeds the sprinkler valve controller logic with a stable snapshot of all four sources.

---
 rtl/data_bus_scanner.sv | 116 +++++++++++
 tb/tb_data_bus_scanner.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_bus_scanner.sv
// Reader side of the 4-source data bus: steps the mux select through i0..i3,
// waits a settle interval per source, samples d and publishes a 4-bit word.
module data_bus_scanner #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       d,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       valid,
  output logic [3:0] data,
  output logic       changed
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_shadow;
  logic [1:0]       r_sel;
  logic             r_busy;
  logic             r_valid;
  logic [3:0]       r_data;
  logic             r_changed;

  logic [3:0]       w_word;

  assign w_word = {d, r_shadow};

  // NOTE: all state lives in one clocked block using <= only; mixing blocking
  // assignments here would make later statements see same-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_shadow  <= 3'b000;
      r_sel     <= 2'b00;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= 4'b0000;
      r_changed <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle; the completion branch
      // below overrides them, so they can never stick high.
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sel <= 2'b00;
          if (start) begin
            r_state <= SETTLE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (r_cnt == LP_CNT_LAST) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          r_cnt <= '0;
          if (r_idx != 2'd3) begin
            r_shadow[r_idx] <= d;
            r_idx           <= r_idx + 2'd1;
            r_sel           <= r_idx + 2'd1;
            r_state         <= SETTLE;
          end else begin
            r_data    <= w_word;
            r_changed <= (w_word != r_data);
            r_valid   <= 1'b1;
            r_idx     <= 2'd0;
            r_sel     <= 2'b00;
            // Continuous mode chains straight into the next scan with no idle gap.
            if (continuous) begin
              r_state <= SETTLE;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_sel   <= 2'b00;
        end
      endcase
    end
  end

  assign s0      = r_sel[0];
  assign s1      = r_sel[1];
  assign busy    = r_busy;
  assign valid   = r_valid;
  assign data    = r_data;
  assign changed = r_changed;

endmodule

// File: tb/tb_data_bus_scanner.sv
// Directed bench for data_bus_scanner: models the 4:1 bus mux around the DUT
// and checks select sequencing, word capture, valid/changed and reset abort.
module tb_data_bus_scanner;

  logic       clk;
  logic       rst;
  logic       start;
  logic       continuous;
  logic       d;
  logic       s0;
  logic       s1;
  logic       busy;
  logic       valid;
  logic [3:0] data;
  logic       changed;
  logic [3:0] src;

  int n_vec;
  int n_err;

  data_bus_scanner #(
    .SETTLE_CYCLES(2),
    .CNT_W        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .continuous(continuous),
    .d         (d),
    .s0        (s0),
    .s1        (s1),
    .busy      (busy),
    .valid     (valid),
    .data      (data),
    .changed   (changed)
  );

  // Bus multiplexer: source ik drives d when s1:s0 == k.
  assign d = src[{s1, s0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that starts a scan (start accepted or previous
  // continuous completion). mode 1: glitch i0 during SETTLE of idx 0;
  // mode 2: start pulses at cycles 3 and 7; mode 3: drop continuous at cycle 5.
  task automatic scan_body(input logic [3:0] exp_data, input logic exp_changed,
                           input logic exp_busy, input int mode);
    check("edge0_sel", {s1, s0}, 2'b00);
    check("edge0_busy", busy, 1'b1);
    for (int e = 1; e <= 12; e++) begin
      if (mode == 1 && e == 1) src[0] = ~src[0];
      if (mode == 1 && e == 2) src[0] = ~src[0];
      if (mode == 2 && (e == 3 || e == 7)) start = 1'b1;
      if (mode == 2 && (e == 4 || e == 8)) start = 1'b0;
      if (mode == 3 && e == 5) continuous = 1'b0;
      tick();
      if (e < 12) begin
        check($sformatf("e%0d_sel", e), {s1, s0}, e / 3);
        check($sformatf("e%0d_valid", e), valid, 1'b0);
        check($sformatf("e%0d_changed", e), changed, 1'b0);
        check($sformatf("e%0d_busy", e), busy, 1'b1);
      end else begin
        check("done_valid", valid, 1'b1);
        check("done_data", data, exp_data);
        check("done_changed", changed, exp_changed);
        check("done_busy", busy, exp_busy);
        check("done_sel", {s1, s0}, 2'b00);
      end
    end
  endtask

  task automatic idle_checks(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check("idle_valid", valid, 1'b0);
      check("idle_changed", changed, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_sel", {s1, s0}, 2'b00);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    src        = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_data", data, 4'b0000);
    check("rst_changed", changed, 1'b0);
    check("rst_sel", {s1, s0}, 2'b00);
    idle_checks(2);

    // Basic scan: i0=1 i1=0 i2=1 i3=0.
    src = 4'b0101;
    pulse_start();
    scan_body(4'b0101, 1'b1, 1'b0, 0);
    idle_checks(2);

    // Same inputs again: no change.
    pulse_start();
    scan_body(4'b0101, 1'b0, 1'b0, 0);
    idle_checks(1);

    // i3 goes high; i0 glitches during SETTLE only.
    src = 4'b1101;
    pulse_start();
    scan_body(4'b1101, 1'b1, 1'b0, 1);
    idle_checks(1);

    // Start while busy is ignored.
    pulse_start();
    scan_body(4'b1101, 1'b0, 1'b0, 2);
    idle_checks(3);

    // Continuous mode: three back-to-back scans, continuous dropped in the third.
    src        = 4'b0101;
    continuous = 1'b1;
    pulse_start();
    scan_body(4'b0101, 1'b1, 1'b1, 0);
    scan_body(4'b0101, 1'b0, 1'b1, 0);
    src = 4'b0011;
    scan_body(4'b0011, 1'b1, 1'b0, 3);
    idle_checks(3);

    // Reset mid-scan after data=0101.
    src = 4'b0101;
    pulse_start();
    scan_body(4'b0101, 1'b1, 1'b0, 0);
    idle_checks(1);
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    check("mid_sel", {s1, s0}, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_data", data, 4'b0000);
    check("abort_valid", valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_sel", {s1, s0}, 2'b00);
    idle_checks(2);
    pulse_start();
    scan_body(4'b0101, 1'b1, 1'b0, 0);
    idle_checks(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
